// File: rtl/calc_pkg.sv
// calc_pkg
//   Types and constants shared by the calculator display path.
//   bcd_digit_t  : one packed BCD digit
//   conv_state_t : binary-to-BCD converter sequencing states
//   DISP_DIGITS  : digit count of the seven-segment display
package calc_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      DONE
   } conv_state_t;

   localparam int DISP_DIGITS = 6;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3
//   Double-dabble digit correction: a digit of 5 or more gets +3 so that the
//   following left shift carries correctly into the next decimal digit.
//   d : digit before correction
//   q : corrected digit
module bcd_add3
   import calc_pkg::*;
(
   input  bcd_digit_t d,
   output bcd_digit_t q
);

   assign q = (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;

endmodule

// File: rtl/result_bcd_converter.sv
// result_bcd_converter
//   Converts the signed ALU result into sign + magnitude BCD for the display,
//   one binary bit per clock (shift-and-add-3).
//   clk, rst   : clock; synchronous active-high reset
//   in_valid   : in_data offered
//   in_data    : signed two's-complement result
//   in_ready   : idle, accepting this cycle
//   out_valid  : one-cycle strobe, out_* just updated
//   out_neg    : result was negative
//   out_bcd    : magnitude digits, digit 0 (LSD) in [3:0]
//   out_blank  : per-digit leading-zero flag; bit 0 is never blanked
module result_bcd_converter
   import calc_pkg::*;
#(
   parameter int IN_W   = 20,
   parameter int DIGITS = DISP_DIGITS
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [IN_W-1:0]       in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic                  out_neg,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic [DIGITS-1:0]     out_blank
);

   localparam int CNT_W = $clog2(IN_W + 1);
   localparam longint unsigned DEC_RANGE = 64'd10 ** DIGITS;
   localparam longint unsigned BIN_RANGE = 64'd1 << (IN_W - 1);
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   // The largest magnitude is 2**(IN_W-1) (most negative input), so the
   // digit field must be able to hold it.
   if (DEC_RANGE <= BIN_RANGE) begin : g_range_chk
      $error("result_bcd_converter: DIGITS too small for IN_W");
   end

   conv_state_t                 state, state_nxt;
   bcd_digit_t [DIGITS-1:0]     scratch, corr;
   logic [4*DIGITS-1:0]         corr_flat, shifted;
   logic [IN_W-1:0]             mag;
   logic                        neg;
   logic [CNT_W-1:0]            cnt;
   logic                        last;
   logic [DIGITS-1:0]           blank_nxt;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3 u_add3 (
         .d (scratch[g]),
         .q (corr[g])
      );
   end

   assign corr_flat = corr;
   // Corrected digits shift left, pulling in the next magnitude bit (MSB first).
   assign shifted   = {corr_flat[4*DIGITS-2:0], mag[IN_W-1]};
   assign last      = (cnt == CNT_W'(IN_W - 1));

   // Leading-zero flags of the value being finished this cycle.
   always_comb begin
      logic zero_above;
      blank_nxt  = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above   = zero_above && (shifted[4*i +: 4] == 4'd0);
         blank_nxt[i] = zero_above && (i > 0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = CONVERT;
         CONVERT: if (last)     state_nxt = DONE;
         DONE:                  state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         neg       <= 1'b0;
         mag       <= '0;
         scratch   <= '0;
         cnt       <= '0;
         out_neg   <= 1'b0;
         out_bcd   <= '0;
         out_blank <= BLANK_RST;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  neg     <= in_data[IN_W-1];
                  // Unsigned result, so the most negative input maps to 2**(IN_W-1).
                  mag     <= in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;
                  scratch <= '0;
                  cnt     <= '0;
               end
            end
            CONVERT: begin
               scratch <= shifted;
               mag     <= {mag[IN_W-2:0], 1'b0};
               cnt     <= cnt + CNT_W'(1);
               if (last) begin
                  out_bcd   <= shifted;
                  out_neg   <= neg;
                  out_blank <= blank_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_result_bcd_converter.sv
module tb_result_bcd_converter;
   import calc_pkg::*;

   localparam int IN_W   = 20;
   localparam int DIGITS = DISP_DIGITS;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                in_valid = 1'b0;
   logic [IN_W-1:0]     in_data = '0;
   logic                in_ready, out_valid, out_neg;
   logic [4*DIGITS-1:0] out_bcd;
   logic [DIGITS-1:0]   out_blank;

   result_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_neg   (out_neg),
      .out_bcd   (out_bcd),
      .out_blank (out_blank)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic                neg;
      logic [4*DIGITS-1:0] bcd;
      logic [DIGITS-1:0]   blank;
      int                  acc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   bad_ready = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain decimal arithmetic on the signed value.
   function automatic exp_t model(input int x, input int acc);
      exp_t e;
      int   mag, p;
      e.neg   = (x < 0);
      mag     = (x < 0) ? -x : x;
      e.bcd   = '0;
      e.blank = '0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         e.bcd[4*i +: 4] = 4'((mag / p) % 10);
         e.blank[i]      = (i > 0) && (mag < p);
         p = p * 10;
      end
      e.acc = acc;
      return e;
   endfunction

   // Offer one value; returns the cycle number of the accepting edge.
   task automatic send(input int d, input bit push, input bit hold, output int acc);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = IN_W'(d);
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 64'(in_ready), 64'd1);
         acc = -1;
         in_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      if (push) sb.push_back(model(d, acc));
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   // Monitor: pops an expectation on every strobe.
   always @(negedge clk) begin
      if (!rst) begin
         if (sb.size() > 0 && cyc >= sb[0].acc && !out_valid && in_ready) bad_ready = 1'b1;
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               check("out_neg",   64'(out_neg),   64'(mon_e.neg));
               check("out_bcd",   64'(out_bcd),   64'(mon_e.bcd));
               check("out_blank", 64'(out_blank), 64'(mon_e.blank));
               check("latency",   64'(cyc),       64'(mon_e.acc + IN_W));
               check("ready_in_done",   64'(in_ready),  64'd0);
               check("ready_in_convert", 64'(bad_ready), 64'd0);
               bad_ready = 1'b0;
            end
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"},  64'(in_ready),  64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_neg"},   64'(out_neg),   64'd0);
      check({tag, "_out_bcd"},   64'(out_bcd),   64'd0);
      check({tag, "_out_blank"}, 64'(out_blank), 64'b111110);
   endtask

   initial begin
      int a1, a2, n, r, d, sel;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_vals("rst");

      send(0,       1, 0, a1);
      send(524287,  1, 0, a1);
      send(-1,      1, 0, a1);
      // back-to-back with in_valid held high
      send(15,      1, 1, a1);
      send(120,     1, 0, a2);
      check("b2b_gap", 64'(a2 - a1), 64'(IN_W + 2));
      send(-524288, 1, 0, a1);

      // abort mid-conversion
      send(-7, 0, 0, a1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_vals("abort");
      repeat (30) @(negedge clk);
      send(42, 1, 0, a1);

      // stray in_valid pulses while busy
      send(999, 1, 0, a1);
      repeat (3) @(negedge clk);
      in_valid = 1'b1; in_data = IN_W'(5);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      in_valid = 1'b1; in_data = IN_W'(-3);
      @(negedge clk);
      in_valid = 1'b0;

      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 3);
         if (sel == 0) begin
            r = $urandom_range(0, (1 << IN_W) - 1);
            d = r - ((r >= (1 << (IN_W - 1))) ? (1 << IN_W) : 0);
         end else if (sel == 1) begin
            d = $urandom_range(0, 200);
            if ($urandom_range(0, 1) == 1) d = -d;
         end else if (sel == 2) begin
            d = $urandom_range(0, 99999);
            if ($urandom_range(0, 1) == 1) d = -d;
         end else begin
            d = ($urandom_range(0, 1) == 1) ? -524288 : 524287;
         end
         send(d, 1, 0, a1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(sb.size()), 64'd0);
      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
